// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI4-Lite register file: response codes, FSM states
// and an index-width helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry valid/data holding register; used to park an AXI channel beat
// until its partner channel arrives.
module axi_lite_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS read/write control registers with
// byte strobes, NUM_RO read-only status registers, SLVERR on illegal access.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_REGS   = 8,
  parameter int                    NUM_RO     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   status_in
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = idx_width(BYTES);
  localparam int IDXW  = ADDR_WIDTH - LSB;
  localparam int WHW   = DATA_WIDTH + BYTES;

  logic                  out_of_reset;
  logic [0:0]            wr_state;
  logic [0:0]            rd_state;
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_hold;
  logic [WHW-1:0]        w_hold;
  logic                  aw_load;
  logic                  w_load;
  logic                  ar_load;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] aw_addr_eff;
  logic [DATA_WIDTH-1:0] w_data_eff;
  logic [BYTES-1:0]      w_strb_eff;
  logic [IDXW-1:0]       wr_idx;
  logic [IDXW-1:0]       rd_idx;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_nxt;
  logic [1:0]            rd_resp_nxt;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic [1:0]            rd_resp_p1;
  logic [1:0]            wr_resp_p1;
  logic [NUM_REGS-1:0]   wr_pulse_p1;
  logic                  unused_addr_lsbs;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) out_of_reset <= 1'b0;
    else                out_of_reset <= 1'b1;
  end

  assign S_AXI_AWREADY = ~aw_full & (wr_state == WR_IDLE) & out_of_reset;
  assign S_AXI_WREADY  = ~w_full  & (wr_state == WR_IDLE) & out_of_reset;
  assign S_AXI_ARREADY = (rd_state == RD_IDLE) & out_of_reset;
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_RVALID  = (rd_state == RD_DATA);
  assign S_AXI_BRESP   = wr_resp_p1;
  assign S_AXI_RRESP   = rd_resp_p1;
  assign S_AXI_RDATA   = rd_data_p1;
  assign wr_pulse      = wr_pulse_p1;

  assign aw_load = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_load  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_load = S_AXI_ARVALID & S_AXI_ARREADY;

  // A beat arriving in the commit cycle bypasses its hold so a write whose
  // second half lands now commits on this edge.
  assign commit = (wr_state == WR_IDLE) & (aw_full | aw_load) & (w_full | w_load);

  axi_lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .load  (aw_load & ~commit),
    .clear (commit),
    .din   (S_AXI_AWADDR),
    .full  (aw_full),
    .dout  (aw_hold)
  );

  axi_lite_hold_reg #(.WIDTH(WHW)) u_w_hold (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .load  (w_load & ~commit),
    .clear (commit),
    .din   ({S_AXI_WSTRB, S_AXI_WDATA}),
    .full  (w_full),
    .dout  (w_hold)
  );

  assign aw_addr_eff               = aw_full ? aw_hold : S_AXI_AWADDR;
  assign {w_strb_eff, w_data_eff}  = w_full ? w_hold : {S_AXI_WSTRB, S_AXI_WDATA};
  assign wr_idx                    = aw_addr_eff[ADDR_WIDTH-1:LSB];
  assign rd_idx                    = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign unused_addr_lsbs          = ^{aw_addr_eff[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = commit & (wr_idx == IDXW'(i));
    end
  end

  // Commit stage: register update, pulse and response all land on one edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_pulse_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wr_hit[i] && w_strb_eff[b]) regs[i][b*8 +: 8] <= w_data_eff[b*8 +: 8];
        end
      end
      wr_pulse_p1 <= wr_hit;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state   <= WR_IDLE;
      wr_resp_p1 <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: if (commit) begin
          wr_state   <= WR_RESP;
          wr_resp_p1 <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
        end
        default: if (S_AXI_BREADY) wr_state <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) begin
        rd_data_nxt = regs[i];
        rd_resp_nxt = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (rd_idx == IDXW'(NUM_REGS + j)) begin
        rd_data_nxt = status_in[j*DATA_WIDTH +: DATA_WIDTH];
        rd_resp_nxt = RESP_OKAY;
      end
    end
  end

  // Read stage: data sampled on the AR handshake edge and held until RREADY.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state   <= RD_IDLE;
      rd_data_p1 <= '0;
      rd_resp_p1 <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: if (ar_load) begin
          rd_state   <= RD_DATA;
          rd_data_p1 <= rd_data_nxt;
          rd_resp_p1 <= rd_resp_nxt;
        end
        default: if (S_AXI_RREADY) rd_state <= RD_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed-vector bench for axi_lite_regfile with a queue-based response scoreboard.
module tb_axi_lite_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [255:0] reg_out;
  logic [7:0]  wr_pulse;
  logic [63:0] status_in = '0;

  int errors = 0;
  int checks = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] mreg[8];

  always #5 clk = ~clk;

  axi_lite_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), {32'h0, reg_out[i*32 +: 32]}, {32'h0, mreg[i]});
  endtask

  task automatic do_aw(input logic [5:0] a);
    bit ok = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = a;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = awready; end
    if (!ok) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b1; wdata = d; wstrb = s;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = wready; end
    if (!ok) chk("w_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [5:0] a);
    bit ok = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = a;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = arready; end
    if (!ok) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Response monitor: every accepted B/R beat is matched against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bvalid && bready) begin
          if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
          else chk("bresp", {62'h0, bresp}, {62'h0, bq.pop_front()});
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
          else begin
            logic [33:0] e;
            e = rq.pop_front();
            chk("rdata", {32'h0, rdata}, {32'h0, e[31:0]});
            chk("rresp", {62'h0, rresp}, {62'h0, e[33:32]});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", {63'h0, awready}, 64'd0);
    chk("rst_wready",  {63'h0, wready},  64'd0);
    chk("rst_arready", {63'h0, arready}, 64'd0);
    chk("rst_bvalid",  {63'h0, bvalid},  64'd0);
    chk("rst_rvalid",  {63'h0, rvalid},  64'd0);
    chk("rst_pulse",   {56'h0, wr_pulse}, 64'd0);
    chk("rst_rdata",   {32'h0, rdata},   64'd0);
    chk_regs("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready_low", {63'h0, awready}, 64'd0);
    @(negedge clk);
    chk("rel_awready", {63'h0, awready}, 64'd1);
    chk("rel_wready",  {63'h0, wready},  64'd1);
    chk("rel_arready", {63'h0, arready}, 64'd1);

    // AW first, W three cycles later
    bq.push_back(2'b00);
    do_aw(6'h04);
    repeat (2) begin @(negedge clk); chk("aw_only_bvalid", {63'h0, bvalid}, 64'd0); end
    do_w(32'hDEADBEEF, 4'hF);
    mreg[1] = 32'hDEADBEEF;
    @(negedge clk);
    chk("w1_bvalid", {63'h0, bvalid}, 64'd1);
    chk("w1_pulse", {56'h0, wr_pulse}, 64'h02);
    chk_regs("w1");
    @(negedge clk);
    chk("w1_pulse_off", {56'h0, wr_pulse}, 64'h00);
    chk("w1_bvalid_off", {63'h0, bvalid}, 64'd0);
    rq.push_back({2'b00, 32'hDEADBEEF});
    do_ar(6'h04);
    @(negedge clk);
    chk("r1_rvalid", {63'h0, rvalid}, 64'd1);

    // Byte-strobe merge with W arriving before AW
    bq.push_back(2'b00);
    fork do_aw(6'h00); do_w(32'h11223344, 4'hF); join
    mreg[0] = 32'h11223344;
    bq.push_back(2'b00);
    do_w(32'h0000AB00, 4'h2);
    @(negedge clk);
    chk("w_only_bvalid", {63'h0, bvalid}, 64'd0);
    do_aw(6'h00);
    mreg[0] = 32'h1122AB44;
    @(negedge clk);
    chk("strb_pulse", {56'h0, wr_pulse}, 64'h01);
    chk_regs("strb");

    // Read-only and unmapped accesses
    status_in = {32'h0BADF00D, 32'hCAFE0001};
    bq.push_back(2'b10);
    fork do_aw(6'h20); do_w(32'h12345678, 4'hF); join
    @(negedge clk);
    chk("ro_pulse", {56'h0, wr_pulse}, 64'h00);
    chk_regs("ro");
    rq.push_back({2'b00, 32'hCAFE0001});
    do_ar(6'h20);
    rq.push_back({2'b00, 32'h0BADF00D});
    do_ar(6'h24);
    rq.push_back({2'b10, 32'h0});
    do_ar(6'h3C);

    // Same-register collision returns pre-write value
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h0});
    fork do_aw(6'h0C); do_w(32'h00000077, 4'hF); do_ar(6'h0C); join
    mreg[3] = 32'h00000077;
    rq.push_back({2'b00, 32'h00000077});
    do_ar(6'h0C);

    // BREADY stall with a concurrent read
    @(posedge clk); #1; bready = 1'b0;
    bq.push_back(2'b00);
    fork do_aw(6'h08); do_w(32'h55AA55AA, 4'hF); join
    mreg[2] = 32'h55AA55AA;
    rq.push_back({2'b00, 32'hDEADBEEF});
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_bvalid", {63'h0, bvalid}, 64'd1);
          chk("stall_bresp", {62'h0, bresp}, 64'd0);
          chk("stall_awready", {63'h0, awready}, 64'd0);
          chk("stall_wready", {63'h0, wready}, 64'd0);
        end
      end
      do_ar(6'h04);
    join
    @(posedge clk); #1; bready = 1'b1;
    @(negedge clk);
    chk_regs("stall");

    // Reset while a response is pending
    @(posedge clk); #1; bready = 1'b0;
    fork do_aw(6'h10); do_w(32'h00000099, 4'hF); join
    @(negedge clk);
    chk("pre_rst_bvalid", {63'h0, bvalid}, 64'd1);
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    chk("async_bvalid", {63'h0, bvalid}, 64'd0);
    chk("async_awready", {63'h0, awready}, 64'd0);
    bready = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (5) begin @(negedge clk); chk("post_rst_bvalid", {63'h0, bvalid}, 64'd0); end
    chk_regs("post_rst");
    rq.push_back({2'b00, 32'h0});
    do_ar(6'h04);

    begin
      bit drained = 1'b0;
      for (int n = 0; n < 50 && !drained; n++) begin
        @(negedge clk);
        drained = (bq.size() == 0) && (rq.size() == 0);
      end
    end
    chk("b_queue_empty", bq.size(), 64'd0);
    chk("r_queue_empty", rq.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
